// File: rtl/clk_div_chain.sv
// Purpose: N-channel clock-enable generator with one tick and one 50% square output per channel, each counting clk or the previous tick.
// Latency: tick/clk_out/pending are registered (1 clk); each cascade stage adds 1 clk behind its source tick.
// Backpressure: cfg_ready drops while the addressed channel already holds an unapplied divisor; out-of-range channels always accept and drop the write.
module clk_div_chain #(
  parameter int N  = 4,
  parameter int W  = 20,
  parameter int CW = 4,
  parameter logic [N*W-1:0] DIV_INIT = {N{{{(W-1){1'b0}}, 1'b1}}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync_clr,
  input  logic [N-1:0]  cascade,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  output logic          cfg_ready,
  output logic [N-1:0]  tick,
  output logic [N-1:0]  clk_out,
  output logic [N-1:0]  pending
);

  logic [W-1:0] cnt     [N];
  logic [W-1:0] div     [N];
  logic [W-1:0] nxt_div [N];

  logic [N-1:0] src;
  logic [N-1:0] accept;
  logic [N-1:0] term;
  logic [N-1:0] apply;
  logic         run;

  // Ready is low only when the addressed in-range channel still holds a write.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = ~pending[i];
    end
  end

  // Source event: every cycle in parallel mode, previous channel's registered tick in cascade mode.
  always_comb begin
    src    = ~cascade;
    src[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      if (cascade[i]) src[i] = tick[i-1];
    end
  end

  // Per-channel terminal count, write acceptance and divisor apply conditions.
  always_comb begin
    run    = en & ~sync_clr;
    accept = '0;
    term   = '0;
    apply  = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = cfg_valid & cfg_ready & (cfg_ch == CW'(i));
      term[i]   = run & (div[i] != '0) & src[i] & (cnt[i] == div[i] - W'(1));
      // An idle channel takes a new divisor immediately; a running one waits for its terminal count.
      apply[i]  = pending[i] & (term[i] | (run & (div[i] == '0)));
    end
  end

  // Counter, tick, square output and divisor reload state for all channels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i]     <= '0;
        div[i]     <= DIV_INIT[W*i +: W];
        nxt_div[i] <= '0;
      end
      tick    <= '0;
      clk_out <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_clr) begin
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
        end else if (!en) begin
          tick[i] <= 1'b0;
        end else if (div[i] == '0) begin
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
        end else if (term[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          // Reloading a zero divisor parks the square output low.
          clk_out[i] <= (apply[i] && nxt_div[i] == '0) ? 1'b0 : ~clk_out[i];
        end else if (src[i]) begin
          cnt[i]  <= cnt[i] + W'(1);
          tick[i] <= 1'b0;
        end else begin
          tick[i] <= 1'b0;
        end

        // Accept and apply are exclusive: accept needs pending low, apply needs it high.
        if (accept[i]) begin
          nxt_div[i] <= cfg_div;
          pending[i] <= 1'b1;
        end else if (apply[i]) begin
          div[i]     <= nxt_div[i];
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_chain.sv
// Purpose: directed bench for clk_div_chain with a period/event-count reference model and literal pins.
// Latency: outputs compared 1 time unit after each rising edge; cfg_ready compared before the edge.
// Backpressure: write helper holds cfg_valid until the model reports ready, with a cycle bound.
module tb_clk_div_chain;

  localparam int N  = 4;
  localparam int W  = 20;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sync_clr;
  logic [N-1:0]  cascade;
  logic          cfg_valid;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_ready;
  logic [N-1:0]  tick;
  logic [N-1:0]  clk_out;
  logic [N-1:0]  pending;

  int vectors;
  int miscompares;

  // Reference model: events counted since the last phase start, level at phase start.
  int           m_div [N];
  int           m_nxt [N];
  int           m_n   [N];
  logic [N-1:0] m_base;
  logic [N-1:0] m_tick;
  logic [N-1:0] m_clk;
  logic [N-1:0] m_pend;
  logic         exp_ready;

  clk_div_chain #(
    .N(N), .W(W), .CW(CW),
    .DIV_INIT({20'd3, 20'd2, 20'd1, 20'd1})
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cascade(cascade),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .tick(tick), .clk_out(clk_out), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div[0] = 1; m_div[1] = 1; m_div[2] = 2; m_div[3] = 3;
    for (int i = 0; i < N; i++) begin
      m_nxt[i] = 0;
      m_n[i]   = 0;
    end
    m_base = '0; m_tick = '0; m_clk = '0; m_pend = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] old_tick;
    logic         src;
    int           c;
    old_tick = m_tick;
    c = int'(cfg_ch);
    exp_ready = (c < N) ? !m_pend[c] : 1'b1;
    for (int i = 0; i < N; i++) begin
      src = 1'b1;
      if (i > 0 && cascade[i]) src = old_tick[i-1];
      if (sync_clr) begin
        m_n[i] = 0; m_base[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
      end else if (!en) begin
        m_tick[i] = 1'b0;
      end else if (m_div[i] == 0) begin
        m_n[i] = 0; m_base[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
        if (m_pend[i]) begin
          m_div[i]  = m_nxt[i];
          m_pend[i] = 1'b0;
        end
      end else if (src) begin
        m_n[i]    = m_n[i] + 1;
        m_tick[i] = (m_n[i] % m_div[i]) == 0;
        m_clk[i]  = m_base[i] ^ (((m_n[i] / m_div[i]) % 2) == 1);
        if (m_tick[i] && m_pend[i]) begin
          m_div[i]  = m_nxt[i];
          m_pend[i] = 1'b0;
          m_n[i]    = 0;
          m_base[i] = m_clk[i];
          if (m_div[i] == 0) begin
            m_clk[i]  = 1'b0;
            m_base[i] = 1'b0;
          end
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    if (cfg_valid && exp_ready && c < N) begin
      m_nxt[c]  = int'(cfg_div);
      m_pend[c] = 1'b1;
    end
  endtask

  // The single per-cycle compare point: ready before the edge, registered outputs after it.
  task automatic step();
    #1;
    model_step();
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic cfg_write(input int ch, input int dv);
    logic done;
    done = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = W'(dv);
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = exp_ready;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL cfg_write_timeout: ch %0d never ready, expected ready within 200 cycles", ch);
    end
  endtask

  task automatic wait_pend_clear();
    for (int k = 0; k < 100 && m_pend != '0; k++) step();
    if (m_pend != '0) begin
      vectors++;
      miscompares++;
      $display("FAIL pend_timeout: pending %0h expected 0 within 100 cycles", m_pend);
    end
  endtask

  initial begin
    int c0, c1, c2, c3, hi3, first;
    logic [11:0] sh;
    vectors = 0; miscompares = 0;
    rst = 1'b0; en = 1'b1; sync_clr = 1'b0; cascade = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    rst = 1'b1;

    // Parallel mode with reset divisors 1,1,2,3.
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; sh = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      c0 += int'(tick[0]); c1 += int'(tick[1]);
      c2 += int'(tick[2]); c3 += int'(tick[3]);
      sh = {sh[10:0], clk_out[2]};
    end
    chk("par_ticks_ch0", c0, 12);
    chk("par_ticks_ch1", c1, 12);
    chk("par_ticks_ch2", c2, 6);
    chk("par_ticks_ch3", c3, 4);
    chk("par_clk_out_ch2_pattern", 32'(sh), 32'h666);

    // Full cascade with every divisor 2.
    for (int ch = 0; ch < N; ch++) cfg_write(ch, 2);
    wait_pend_clear();
    cascade = 4'b1110;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    c0 = 0; c3 = 0; hi3 = 0; first = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      c0 += int'(tick[0]);
      if (tick[3]) begin
        c3++;
        if (first == 0) first = k;
      end
      hi3 += int'(clk_out[3]);
    end
    chk("casc_ticks_ch0", c0, 32);
    chk("casc_ticks_ch3", c3, 3);
    chk("casc_first_tick_ch3", first, 19);
    chk("casc_clk_out_ch3_high", hi3, 30);

    // Mid-period reload 5 -> 3 on ch1, with a stalled second write.
    cascade = '0;
    cfg_write(1, 5);
    wait_pend_clear();
    repeat (2) step();
    cfg_write(1, 3);
    chk("reload_pending_ch1", 32'(pending[1]), 32'h1);
    cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 20'd4;
    #1;
    chk("reload_second_ready", 32'(cfg_ready), 32'h0);
    step();
    cfg_valid = 1'b0;
    wait_pend_clear();
    c1 = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      c1 += int'(tick[1]);
    end
    chk("reload_ticks_ch1", c1, 3);

    // Idle channel takes a write immediately; writing 0 stops it after the period.
    cfg_write(2, 0);
    for (int k = 0; k < 50 && m_div[2] != 0; k++) step();
    cfg_write(2, 7);
    step();
    chk("idle_apply_pending_ch2", 32'(pending[2]), 32'h0);
    first = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (tick[2] && first == 0) first = k;
    end
    chk("idle_first_tick_ch2", first, 7);
    cfg_write(2, 0);
    c2 = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k > 10) c2 += int'(tick[2]);
    end
    chk("stop_ticks_ch2", c2, 0);
    chk("stop_clk_out_ch2", 32'(clk_out[2]), 32'h0);

    // Global enable hold, then synchronous clear.
    repeat (3) step();
    en = 1'b0;
    c0 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      c0 += int'(tick != '0);
    end
    chk("en_off_ticks", c0, 0);
    en = 1'b1;
    repeat (6) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("sync_clr_tick", 32'(tick), 32'h0);
    chk("sync_clr_clk_out", 32'(clk_out), 32'h0);
    repeat (6) step();

    // Asynchronous reset with a write pending.
    cfg_write(1, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_clk_out", 32'(clk_out), 32'h0);
    chk("arst_pending", 32'(pending), 32'h0);
    model_reset();
    cascade = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    c2 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      c2 += int'(tick[2]);
    end
    chk("arst_div_init_ch2", c2, 6);

    // Out-of-range channel: always ready, nothing changes.
    cfg_valid = 1'b1; cfg_ch = 4'd15; cfg_div = 20'd9;
    #1;
    chk("oor_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    chk("oor_pending", 32'(pending), 32'h0);
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_chain.md
Name: clk_div_chain

Overview:
- N-channel programmable clock-enable generator and the parametrised successor of the fixed serial even-divider chain.
- All logic is on one clock. Each channel produces a one-cycle tick enable and a 50%-duty square output, with no ripple clocks.
- Each channel is selected at runtime to count either the base clock (parallel) or the previous channel's tick (cascade).
- Divide ratios reload at runtime through a valid/ready handshake, glitch-free at the terminal count. Sits under the 1 MHz base clock and feeds timing enables to the rest of the CPLD design.

Parameters:
- N, 4, number of channels (1..16).
- W, 20, divisor/counter width per channel.
- CW, 4, channel-select width; must satisfy 2**CW >= N.
- DIV_INIT, {N{20'd1}}, packed reset divisors; channel i occupies bits [W*(i+1)-1:W*i].

Ports:
- clk  in  1  base clock (1 MHz nominal).
- rst  in  1  asynchronous active-low reset.
- en  in  1  global synchronous enable.
- sync_clr  in  1  synchronous phase clear of all channels.
- cascade  in  N  per-channel source select; bit 0 is ignored (channel 0 always counts clk).
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  CW  target channel.
- cfg_div  in  W  new divisor.
- cfg_ready  out  1  write accepted when high with cfg_valid.
- tick  out  N  one-cycle enable per channel.
- clk_out  out  N  square output per channel.
- pending  out  N  divisor write waiting to apply.

Behaviour:
- Reset (rst=0, async):
  - cnt=0, tick=0, clk_out=0, pending=0.
  - div_i=DIV_INIT slice.
  - The reset is released synchronously by the surrounding reset logic, not inside this block.
- Source event src_i:
  - src_i = 1 every cycle when i==0 or cascade[i]=0.
  - src_i = tick[i-1] (registered value) when cascade[i]=1.
- Count, per cycle, with en=1 and sync_clr=0:
  - If div_i==0: channel idle; cnt_i=0, tick_i=0, clk_out_i holds 0.
  - Else if src_i and cnt_i==div_i-1: cnt_i<=0, tick_i<=1, clk_out_i<=~clk_out_i.
  - Else if src_i: cnt_i<=cnt_i+1, tick_i<=0.
  - Else: tick_i<=0.
- Timing:
  - tick period = div_i source events.
  - clk_out period = 2*div_i source events, duty exactly 50%.
  - Each cascade stage adds 1 clk of latency relative to its source tick.
- en=0:
  - Counters and clk_out hold; tick forced 0 the next cycle.
  - Pending writes still apply when their channel's terminal condition next occurs with en=1.
- sync_clr=1:
  - Next cycle: all cnt=0, tick=0, clk_out=0.
  - div and pending are unchanged.
  - Priority: rst > sync_clr > en.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] when cfg_ch<N; cfg_ready=1 when cfg_ch>=N (write discarded).
  - Accept on cfg_valid & cfg_ready: nxt_div_ch<=cfg_div, pending[ch]<=1.
  - Pending apply with current div_ch!=0: applied in the same cycle the channel reaches terminal count (tick asserted with the old ratio); div<=nxt_div, pending<=0. The next period uses the new ratio.
  - Pending apply with current div_ch==0: applied the cycle after acceptance, cnt=0. First tick arrives new_div source events later.
  - Writing 0 stops the channel after its current period completes; clk_out is then forced 0 at apply.
  - A write to a channel with pending=1 stalls (cfg_ready=0) until that write applies.
  - A write during sync_clr is accepted normally.
- Arithmetic:
  - Counters are W bits; the compare uses div_i-1 in W bits and is only evaluated when div_i!=0.
  - div=2**W-1 is the maximum; no wrap-around is possible.
- Width and latency:
  - tick and clk_out are registered outputs; pending is registered.
  - cfg_ready is combinational from pending and cfg_ch.
- Mid-operation:
  - Changing cascade[i] takes effect on the next cycle's source selection.
  - cnt is not cleared on a cascade change; software issues sync_clr for phase alignment.

Test Plan:
- Reset with DIV_INIT={4'd..:3,2,1,1} (ch3=3, ch2=2, ch1=1, ch0=1), cascade=0, en=1 -> every channel's tick fires every div_i cycles (ch0 and ch1 every cycle, ch2 every 2, ch3 every 3); ch2 clk_out period 4 cycles at 50% duty.
- cascade=4'b1110, all div=2 -> ch0 tick every 2 cycles; ch3 tick every 16 cycles; ch3 clk_out period 32 cycles; each stage's first tick lags the previous by 1 clk plus its count.
- With ch1 div=5 running, write cfg_div=3 mid-period -> pending[1]=1 and a second write to ch1 sees cfg_ready=0. The old period completes with 5; the next ticks are spaced 3 apart, and pending clears on the apply cycle.
- ch2 div=0 (idle), write 7 -> applied the next cycle; first tick 7 cycles later. Then write 0 -> current period finishes, then tick and clk_out stay 0.
- en=0 for 10 cycles mid-count -> tick=0 and counts frozen; resume continues from the held count. sync_clr pulse -> all cnt, clk_out and tick are 0 the next cycle; divisors retained.
- Assert rst low mid-count with a write pending -> all outputs 0 immediately; pending clears; div returns to DIV_INIT. Write to cfg_ch=15 with N=4 -> cfg_ready=1 and no state change.
